// File: rtl/sata_dma_write_sequencer_if.sv
// Handshake bundle between the command layer, the DMA-write sequencer and the data-FIS shaper.
// Ports: cmd_* (command in), act_* (DMA Activate), shp_*/mon_eop (shaper), abort, done_*, busy.
interface sata_dma_write_sequencer_if;
    logic        cmd_valid;
    logic [15:0] cmd_sectors;
    logic        cmd_ready;
    logic        act_valid;
    logic        act_ready;
    logic        shp_valid;
    logic [15:0] shp_count;
    logic        shp_ready;
    logic        mon_eop;
    logic        abort;
    logic        done_valid;
    logic        done_err;
    logic [16:0] done_sectors;
    logic        busy;

    modport master (
        output cmd_valid, cmd_sectors, act_valid, shp_ready, mon_eop, abort,
        input  cmd_ready, act_ready, shp_valid, shp_count,
        input  done_valid, done_err, done_sectors, busy
    );

    modport slave (
        input  cmd_valid, cmd_sectors, act_valid, shp_ready, mon_eop, abort,
        output cmd_ready, act_ready, shp_valid, shp_count,
        output done_valid, done_err, done_sectors, busy
    );
endinterface

// File: rtl/sata_dma_write_sequencer.sv
// Host->device DMA-write data-phase sequencer: splits one command into bursts, one per DMA Activate.
// Ports: clk, reset (async, active-high), bus (slave side of sata_dma_write_sequencer_if).
module sata_dma_write_sequencer #(
    parameter int unsigned BURST_SECTORS = 16,
    parameter logic [31:0] ACT_TIMEOUT   = 32'd1500000
) (
    input logic                         clk,
    input logic                         reset,
    sata_dma_write_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACT,
        ISSUE,
        XFER,
        DONE
    } state_t;

    localparam logic [16:0] BURST_MAX = 17'(BURST_SECTORS);

    state_t      state;
    logic [16:0] rem;
    logic [16:0] burst;
    logic [16:0] sent;
    logic [31:0] timer;
    logic        err;

    logic [16:0] next_burst;
    logic        act_expired;

    assign next_burst  = (rem < BURST_MAX) ? rem : BURST_MAX;
    assign act_expired = (ACT_TIMEOUT != 32'd0) &&
                         (timer == ACT_TIMEOUT - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rem              <= '0;
            burst            <= '0;
            sent             <= '0;
            timer            <= '0;
            err              <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.act_ready    <= 1'b0;
            bus.shp_valid    <= 1'b0;
            bus.shp_count    <= '0;
            bus.done_valid   <= 1'b0;
            bus.done_err     <= 1'b0;
            bus.done_sectors <= '0;
            bus.busy         <= 1'b0;
        end else begin
            bus.done_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        rem           <= (bus.cmd_sectors == 16'd0) ?
                                         17'd65536 : {1'b0, bus.cmd_sectors};
                        sent          <= '0;
                        err           <= 1'b0;
                        timer         <= '0;
                        state         <= WAIT_ACT;
                        bus.cmd_ready <= 1'b0;
                        bus.act_ready <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                WAIT_ACT: begin
                    timer <= timer + 32'd1;
                    // abort beats act, act beats a timeout on the same cycle
                    if (bus.abort) begin
                        err           <= 1'b1;
                        state         <= DONE;
                        bus.act_ready <= 1'b0;
                    end else if (bus.act_valid) begin
                        burst         <= next_burst;
                        state         <= ISSUE;
                        bus.act_ready <= 1'b0;
                        bus.shp_valid <= 1'b1;
                        bus.shp_count <= next_burst[15:0];
                    end else if (act_expired) begin
                        err           <= 1'b1;
                        state         <= DONE;
                        bus.act_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        err           <= 1'b1;
                        state         <= DONE;
                        bus.shp_valid <= 1'b0;
                    end else if (bus.shp_ready) begin
                        state         <= XFER;
                        bus.shp_valid <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus.abort) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (bus.mon_eop) begin
                        sent <= sent + burst;
                        rem  <= rem - burst;
                        if (rem == burst) begin
                            state <= DONE;
                        end else begin
                            timer         <= '0;
                            state         <= WAIT_ACT;
                            bus.act_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    bus.cmd_ready    <= 1'b1;
                    bus.busy         <= 1'b0;
                    bus.done_valid   <= 1'b1;
                    bus.done_err     <= err;
                    bus.done_sectors <= sent;
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.act_ready <= 1'b0;
                    bus.shp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_dma_write_sequencer.sv
// Self-checking bench for sata_dma_write_sequencer: directed commands against a burst/result model.
// Ports: none (drives the DUT through a sata_dma_write_sequencer_if instance).
module tb_sata_dma_write_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sata_dma_write_sequencer_if bus ();

    sata_dma_write_sequencer #(
        .BURST_SECTORS (16),
        .ACT_TIMEOUT   (32'd100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    int exp_bursts[$];
    int exp_err[$];
    int exp_sent[$];
    int issued[$];

    localparam int S_ACT  = 0;
    localparam int S_SHP  = 1;
    localparam int S_DONE = 2;
    localparam int S_CMD  = 3;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            S_ACT:   return bus.act_ready;
            S_SHP:   return bus.shp_valid;
            S_DONE:  return bus.done_valid;
            S_CMD:   return bus.cmd_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int k, input string nm);
        int n = 0;
        while (!sig(k) && n < 200) begin
            step();
            n++;
        end
        chk(nm, sig(k), 1);
    endtask

    // model: burst list is the sector count carved into chunks of at most 16
    task automatic expect_bursts(input int n);
        int r = (n == 0) ? 65536 : n;
        while (r > 0) begin
            int b = (r < 16) ? r : 16;
            exp_bursts.push_back(b);
            r -= b;
        end
    endtask

    task automatic expect_done(input int e, input int s);
        exp_err.push_back(e);
        exp_sent.push_back(s);
    endtask

    task automatic send_cmd(input int n);
        wait_until(S_CMD, "wait_cmd_ready");
        bus.cmd_valid   = 1'b1;
        bus.cmd_sectors = 16'(n);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic give_act();
        wait_until(S_ACT, "wait_act_ready");
        bus.act_valid = 1'b1;
        step();
        bus.act_valid = 1'b0;
        chk("lat_act_shp", bus.shp_valid, 1);
    endtask

    task automatic finish_burst(input logic ab);
        wait_until(S_SHP, "wait_shp_valid");
        bus.shp_ready = 1'b1;
        step();
        bus.shp_ready = 1'b0;
        step();
        bus.mon_eop = 1'b1;
        bus.abort   = ab;
        step();
        bus.mon_eop = 1'b0;
        bus.abort   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_vs_busy", bus.cmd_ready, !bus.busy);
            chk("act_shp_excl", bus.act_ready & bus.shp_valid, 0);
            if (bus.shp_valid) begin
                if (exp_bursts.size() == 0) begin
                    chk("shp_unexpected", 1, 0);
                end else begin
                    chk("shp_count", bus.shp_count, exp_bursts[0]);
                    if (bus.shp_ready && !bus.abort) begin
                        issued.push_back(int'(bus.shp_count));
                        void'(exp_bursts.pop_front());
                    end
                end
            end
            if (bus.done_valid) begin
                done_cnt++;
                if (exp_err.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("done_err", bus.done_err, exp_err[0]);
                    chk("done_sectors", bus.done_sectors, exp_sent[0]);
                    void'(exp_err.pop_front());
                    void'(exp_sent.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        bus.cmd_valid   = 1'b0;
        bus.cmd_sectors = '0;
        bus.act_valid   = 1'b0;
        bus.shp_ready   = 1'b0;
        bus.mon_eop     = 1'b0;
        bus.abort       = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_act_ready", bus.act_ready, 0);
        chk("rst_shp_valid", bus.shp_valid, 0);
        chk("rst_shp_count", bus.shp_count, 0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_done_sectors", bus.done_sectors, 0);
        chk("rst_busy", bus.busy, 0);

        // 40 sectors: 16,16,8; a stray eop while waiting for act is ignored
        issued.delete();
        d0 = done_cnt;
        expect_bursts(40);
        expect_done(0, 40);
        send_cmd(40);
        chk("lat_cmd_act", bus.act_ready, 1);
        bus.mon_eop = 1'b1;
        step();
        bus.mon_eop = 1'b0;
        chk("eop_in_wait_act", bus.act_ready, 1);
        give_act();
        finish_burst(1'b0);
        chk("lat_eop_act", bus.act_ready, 1);
        give_act();
        finish_burst(1'b0);
        give_act();
        finish_burst(1'b0);
        wait_until(S_DONE, "t1_done");
        step();
        step();
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_nbursts", issued.size(), 3);
        if (issued.size() == 3) begin
            chk("t1_b0", issued[0], 16);
            chk("t1_b1", issued[1], 16);
            chk("t1_b2", issued[2], 8);
        end

        // activate timeout: done 101 clocks after WAIT_ACT entry
        expect_done(1, 0);
        send_cmd(8);
        n = 0;
        while (!bus.done_valid && n < 300) begin
            step();
            n++;
        end
        chk("timeout_latency", n, 101);
        step();

        // act on the exact timeout cycle wins
        expect_bursts(8);
        expect_done(0, 8);
        send_cmd(8);
        repeat (99) step();
        chk("pre_timeout_act_ready", bus.act_ready, 1);
        bus.act_valid = 1'b1;
        step();
        bus.act_valid = 1'b0;
        chk("act_at_timeout", bus.shp_valid, 1);
        chk("act_at_timeout_nodone", bus.done_valid, 0);
        finish_burst(1'b0);
        wait_until(S_DONE, "t5b_done");
        step();

        // act_valid outside WAIT_ACT is ignored
        bus.act_valid = 1'b1;
        step();
        bus.act_valid = 1'b0;
        chk("act_idle_busy", bus.busy, 0);
        chk("act_idle_ready", bus.act_ready, 0);
        expect_bursts(16);
        expect_done(0, 16);
        send_cmd(16);
        give_act();
        bus.act_valid = 1'b1;
        step();
        bus.act_valid = 1'b0;
        chk("act_issue_shp", bus.shp_valid, 1);
        chk("act_issue_ready", bus.act_ready, 0);
        bus.shp_ready = 1'b1;
        step();
        bus.shp_ready = 1'b0;
        bus.act_valid = 1'b1;
        step();
        bus.act_valid = 1'b0;
        chk("act_xfer_ready", bus.act_ready, 0);
        chk("act_xfer_shp", bus.shp_valid, 0);
        chk("act_xfer_busy", bus.busy, 1);
        bus.mon_eop = 1'b1;
        step();
        bus.mon_eop = 1'b0;
        wait_until(S_DONE, "t5a_done");
        step();

        // abort together with eop of the 2nd burst
        expect_bursts(32);
        expect_done(1, 16);
        send_cmd(32);
        give_act();
        finish_burst(1'b0);
        give_act();
        finish_burst(1'b1);
        chk("abort_no_act", bus.act_ready, 0);
        wait_until(S_DONE, "t4_done");
        step();

        // 65536 sectors
        issued.delete();
        expect_bursts(0);
        expect_done(0, 65536);
        send_cmd(0);
        repeat (4096) begin
            give_act();
            finish_burst(1'b0);
        end
        wait_until(S_DONE, "t2_done");
        step();
        chk("t2_nbursts", issued.size(), 4096);

        // reset in the middle of XFER
        expect_bursts(8);
        send_cmd(8);
        give_act();
        bus.shp_ready = 1'b1;
        step();
        bus.shp_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        exp_bursts.delete();
        exp_err.delete();
        exp_sent.delete();
        chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
        chk("rst_mid_shp_valid", bus.shp_valid, 0);
        chk("rst_mid_busy", bus.busy, 0);
        step();
        reset = 1'b0;
        chk("rst_edge_cmd_ready", bus.cmd_ready, 1);
        chk("rst_edge_busy", bus.busy, 0);
        expect_bursts(4);
        expect_done(0, 4);
        send_cmd(4);
        give_act();
        finish_burst(1'b0);
        wait_until(S_DONE, "t6_done");
        step();
        step();

        chk("model_bursts_left", exp_bursts.size(), 0);
        chk("model_done_left", exp_err.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
